// File: rtl/sm_hex_display_pkg.sv
// Shared constants for the multiplexed hex display: segment width, bit order
// and the active-high hex-to-segment table.
package sm_hex_display_pkg;

   localparam int SEG_W = 7;

   // Bit positions inside the {g,f,e,d,c,b,a} segment vector
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] seg,
                                                     input bit active_low);
      return active_low ? ~seg : seg;
   endfunction

endpackage

// File: rtl/sm_hex_display_n_if.sv
// Display-side bundle: value/dot/enable inputs from the core, segment and anode pins out.
// SM_HEX_DISPLAY_DIM_EN adds the brightness input.
interface sm_hex_display_n_if #(
   parameter int DIGITS = 8,
   parameter int DIV_W  = 16
);
   import sm_hex_display_pkg::*;

   logic [4*DIGITS-1:0] number;
   logic [DIGITS-1:0]   dots;
   logic [DIGITS-1:0]   digit_en;
   logic                blank_lz;
   logic [DIV_W-1:0]    tick_div;
`ifdef SM_HEX_DISPLAY_DIM_EN
   logic [3:0]          brightness;
`endif
   logic [SEG_W-1:0]    seven_segments;
   logic                dot;
   logic [DIGITS-1:0]   anodes;
   logic                frame_start;

   modport master (
      output number, dots, digit_en, blank_lz, tick_div,
`ifdef SM_HEX_DISPLAY_DIM_EN
      output brightness,
`endif
      input  seven_segments, dot, anodes, frame_start
   );

   modport slave (
      input  number, dots, digit_en, blank_lz, tick_div,
`ifdef SM_HEX_DISPLAY_DIM_EN
      input  brightness,
`endif
      output seven_segments, dot, anodes, frame_start
   );

endinterface

// File: rtl/sm_hex_to_seg.sv
// Nibble to active-high 7-segment pattern, purely combinational.
module sm_hex_to_seg
   import sm_hex_display_pkg::*;
(
   input  logic [3:0]       nibble,
   output logic [SEG_W-1:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sm_hex_display_n.sv
// N-digit multiplexed 7-segment driver with prescaler, blanking and frame-boundary shadowing.
// Pins registered one clock after the digit index; SM_HEX_DISPLAY_DIM_EN adds PWM anode dimming.
module sm_hex_display_n
   import sm_hex_display_pkg::*;
#(
   parameter int DIGITS         = 8,
   parameter int DIV_W          = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   sm_hex_display_n_if.slave  bus
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                init_q, init_d;
   logic [4*DIGITS-1:0] shd_num_q, shd_num_d;
   logic [DIGITS-1:0]   shd_dots_q, shd_dots_d;
   logic [DIGITS-1:0]   shd_en_q, shd_en_d;
   logic                shd_blz_q, shd_blz_d;
   logic                fs_q, fs_d;
   logic [SEG_W-1:0]    seg_q, seg_d;
   logic                dot_q, dot_d;
   logic [DIGITS-1:0]   an_q, an_d;
`ifdef SM_HEX_DISPLAY_DIM_EN
   logic [3:0]          pwm_cnt_q, pwm_cnt_d;
`endif

   logic                tick, last, load, upper_zero, blank, an_on;
   logic [3:0]          nibble;
   logic [SEG_W-1:0]    seg_raw;
   logic [DIGITS-1:0]   an_hot;

   assign nibble = shd_num_q[{idx_q, 2'b00} +: 4];

   sm_hex_to_seg u_hex_to_seg (
      .nibble (nibble),
      .seg    (seg_raw)
   );

   // The post-reset load cycle holds the prescaler so frame 1 has a full digit-0 slot
   always_comb begin
      tick   = (cnt_q >= bus.tick_div);
      last   = (idx_q == IDX_W'(DIGITS - 1));
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      if (!init_q) begin
         cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
         if (tick) begin
            idx_d = last ? '0 : idx_q + IDX_W'(1);
         end
      end
      load       = init_q | (tick & last);
      init_d     = 1'b0;
      fs_d       = load;
      shd_num_d  = load ? bus.number   : shd_num_q;
      shd_dots_d = load ? bus.dots     : shd_dots_q;
      shd_en_d   = load ? bus.digit_en : shd_en_q;
      shd_blz_d  = load ? bus.blank_lz : shd_blz_q;
   end

   always_comb begin
      upper_zero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= int'(idx_q) && shd_num_q[i*4 +: 4] != 4'h0) begin
            upper_zero = 1'b0;
         end
      end
      blank = ~shd_en_q[idx_q] | (shd_blz_q & (idx_q != '0) & upper_zero);
`ifdef SM_HEX_DISPLAY_DIM_EN
      pwm_cnt_d = pwm_cnt_q + 4'd1;
      an_on     = ~blank & (pwm_cnt_q <= bus.brightness);
`else
      an_on     = ~blank;
`endif
      an_hot         = '0;
      an_hot[idx_q]  = an_on;
      an_d  = AN_ACTIVE_LOW ? ~an_hot : an_hot;
      seg_d = seg_polarity(blank ? {SEG_W{1'b0}} : seg_raw, SEG_ACTIVE_LOW);
      dot_d = (~blank & shd_dots_q[idx_q]) ^ SEG_ACTIVE_LOW;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         init_q     <= 1'b1;
         shd_num_q  <= '0;
         shd_dots_q <= '0;
         shd_en_q   <= '0;
         shd_blz_q  <= 1'b0;
         fs_q       <= 1'b0;
         seg_q      <= {SEG_W{SEG_ACTIVE_LOW}};
         dot_q      <= SEG_ACTIVE_LOW;
         an_q       <= {DIGITS{AN_ACTIVE_LOW}};
`ifdef SM_HEX_DISPLAY_DIM_EN
         pwm_cnt_q  <= '0;
`endif
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         init_q     <= init_d;
         shd_num_q  <= shd_num_d;
         shd_dots_q <= shd_dots_d;
         shd_en_q   <= shd_en_d;
         shd_blz_q  <= shd_blz_d;
         fs_q       <= fs_d;
         seg_q      <= seg_d;
         dot_q      <= dot_d;
         an_q       <= an_d;
`ifdef SM_HEX_DISPLAY_DIM_EN
         pwm_cnt_q  <= pwm_cnt_d;
`endif
      end
   end

   assign bus.seven_segments = seg_q;
   assign bus.dot            = dot_q;
   assign bus.anodes         = an_q;
   assign bus.frame_start    = fs_q;

endmodule

// File: tb/tb_sm_hex_display_n.sv
// Frame-level scoreboard bench for sm_hex_display_n (8 digits, active-low pins).
module tb_sm_hex_display_n;

   typedef struct packed {
      logic       fs;
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_bad   = 0;
   int   per     = 4;
   obs_t exp_q[$];

   always #5 clk = ~clk;

   sm_hex_display_n_if #(.DIGITS(8), .DIV_W(16)) bus ();

   sm_hex_display_n #(
      .DIGITS(8), .DIV_W(16), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;  default: return 7'b1110001;
      endcase
   endfunction

   task automatic push_frame(input logic [31:0] num, input logic [7:0] dts,
                             input logic [7:0] en, input logic blz);
      int   top = 0;
      logic blk;
      obs_t e;
      for (int i = 0; i < 8; i++) if (num[i*4 +: 4] != 4'h0) top = i;
      for (int d = 0; d < 8; d++) begin
         blk = !en[d] || (blz && d > top);
         for (int p = 0; p < per; p++) begin
            e.fs  = (d == 7 && p == per - 1);
            e.an  = blk ? 8'hFF : ~(8'h01 << d);
            e.seg = blk ? 7'h7F : ~hex7(num[d*4 +: 4]);
            e.dp  = blk ? 1'b1 : ~dts[d];
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic run_frame(input int chg_at, input logic [31:0] chg_num);
      obs_t got, e;
      int   k = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         got = {bus.frame_start, bus.anodes, bus.seven_segments, bus.dot};
         e   = exp_q.pop_front();
         chk($sformatf("frame_s%0d", k), 32'(got), 32'(e));
         if (k == chg_at) bus.number = chg_num;
         k++;
      end
   endtask

   task automatic wait_fs(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.frame_start && n < 200);
      if (!bus.frame_start) chk("fs_timeout", 32'(bus.frame_start), 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_an"},  32'(bus.anodes),         32'hFF);
      chk({tag, "_seg"}, 32'(bus.seven_segments), 32'h7F);
      chk({tag, "_dot"}, 32'(bus.dot),            32'd1);
      chk({tag, "_fs"},  32'(bus.frame_start),    32'd0);
   endtask

   initial begin
      int n;
      int on_cnt;
      rst          = 1'b1;
      bus.number   = 32'h1234_5678;
      bus.dots     = 8'h00;
      bus.digit_en = 8'hFF;
      bus.blank_lz = 1'b0;
      bus.tick_div = 16'd3;
`ifdef SM_HEX_DISPLAY_DIM_EN
      bus.brightness = 4'd15;
`endif
      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst = 1'b0;
      wait_fs(n);
      chk("fs_first", 32'(n), 32'd1);
      push_frame(32'h1234_5678, 8'h00, 8'hFF, 1'b0);
      run_frame(-1, 32'h0);

      // leading-zero blanking on, then off
      bus.number   = 32'h0000_00A0;
      bus.blank_lz = 1'b1;
      push_frame(32'h1234_5678, 8'h00, 8'hFF, 1'b0);
      run_frame(-1, 32'h0);
      bus.blank_lz = 1'b0;
      push_frame(32'h0000_00A0, 8'h00, 8'hFF, 1'b1);
      run_frame(-1, 32'h0);
      push_frame(32'h0000_00A0, 8'h00, 8'hFF, 1'b0);
      run_frame(-1, 32'h0);

      // input change mid-frame must wait for the next frame
      bus.number = 32'h1111_1111;
      push_frame(32'h0000_00A0, 8'h00, 8'hFF, 1'b0);
      run_frame(-1, 32'h0);
      push_frame(32'h1111_1111, 8'h00, 8'hFF, 1'b0);
      run_frame(10, 32'h2222_2222);
      push_frame(32'h2222_2222, 8'h00, 8'hFF, 1'b0);
      run_frame(-1, 32'h0);

      // per-digit enable and dot
      bus.digit_en = 8'b1111_0111;
      bus.dots     = 8'h01;
      push_frame(32'h2222_2222, 8'h00, 8'hFF, 1'b0);
      run_frame(-1, 32'h0);
      bus.number   = 32'h1234_5678;
      bus.digit_en = 8'hFF;
      bus.dots     = 8'h00;
      push_frame(32'h2222_2222, 8'h01, 8'hF7, 1'b0);
      run_frame(-1, 32'h0);

      // prescaler: lowered tick_div wraps at once, then tick_div=0 steps every clock
      bus.tick_div = 16'd100;
      repeat (50) @(negedge clk);
      bus.tick_div = 16'd10;
      @(negedge clk);
      chk("pre_hold", 32'(bus.anodes), 32'hFE);
      @(negedge clk);
      chk("pre_wrap", 32'(bus.anodes), 32'hFD);
      bus.tick_div = 16'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("pre_fast%0d", i), 32'(bus.anodes), 32'(8'(~(8'h02 << i))));
      end
      bus.tick_div = 16'd3;
      wait_fs(n);
      push_frame(32'h1234_5678, 8'h00, 8'hFF, 1'b0);
      run_frame(-1, 32'h0);

      // one-cycle reset in the middle of a frame
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset("mid_rst");
      rst = 1'b0;
      wait_fs(n);
      chk("fs_after_rst", 32'(n), 32'd1);
      push_frame(32'h1234_5678, 8'h00, 8'hFF, 1'b0);
      run_frame(-1, 32'h0);

`ifdef SM_HEX_DISPLAY_DIM_EN
      bus.brightness = 4'd3;
      repeat (2) @(negedge clk);
      on_cnt = 0;
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         if (bus.anodes != 8'hFF) on_cnt++;
      end
      chk("dim_duty", 32'(on_cnt), 32'd32);
`else
      on_cnt = 0;
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/sm_hex_display_n.md
Name: sm_hex_display_n

Overview:
- Parametrised N-digit multiplexed 7-segment driver with its own refresh prescaler.
- Successor to the fixed 8-digit display: digit count, polarity and refresh rate are configurable.
- Adds leading-zero blanking, per-digit enables, per-digit dots and tear-free frame-boundary latching.
- Sits between core debug outputs (e.g. register readout) and the board segment/anode pins, clocked directly from the board clock.

Parameters:
- DIGITS, 8, number of digits/anodes (1..16).
- DIV_W, 16, width of the prescaler and of tick_div.
- SEG_ACTIVE_LOW, 1, 1 = segments and dot driven low when lit.
- AN_ACTIVE_LOW, 1, 1 = selected anode driven low.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- number  in  4*DIGITS  hex value; nibble i (number[4i+3:4i]) shown on digit i; digit 0 = least significant.
- dots  in  DIGITS  dot request per digit.
- digit_en  in  DIGITS  0 forces digit blank.
- blank_lz  in  1  enable leading-zero blanking.
- tick_div  in  DIV_W  digit period = tick_div+1 clocks.
- seven_segments  out  7  {g,f,e,d,c,b,a}.
- dot  out  1  decimal point of the active digit.
- anodes  out  DIGITS  one-hot digit select.
- frame_start  out  1  one-cycle pulse when shadow registers load.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state:
  - prescaler = 0, digit index = 0, shadow registers = 0, frame_start = 0.
  - All anodes inactive; seven_segments and dot unlit (polarity per parameters).
- Prescaler:
  - Counts 0..tick_div. When count >= tick_div it returns to 0 and the index advances (DIGITS-1 wraps to 0).
  - The >= compare means a lowered tick_div mid-count recovers in one cycle.
  - tick_div = 0: index advances every clock.
- Shadow load:
  - Loads number, dots, digit_en and blank_lz in the first cycle after rst deasserts.
  - Also loads in the cycle the index wraps DIGITS-1 -> 0.
  - frame_start is registered and is high for exactly the cycle after each load.
  - Input changes mid-frame never show until the next frame.
- Blanking:
  - Digit i is blank if shadow digit_en[i] = 0.
  - Digit i is also blank if shadow blank_lz = 1, i != 0, and nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked by blank_lz.
  - A blank digit keeps all anodes inactive for its slot; segments and dot are unlit.
- Decode: standard hex (active-high view):
  - 0 = 0111111, 1 = 0000110, 8 = 1111111.
  - A = 1110111, b = 1111100, C = 0111001, d = 1011110, E = 1111001, F = 1110001.
  - The output is inverted when SEG_ACTIVE_LOW = 1.
- Latency: anodes, seven_segments and dot are all registered and update together, one clock after the index changes. No glitch combination appears on the pins.
- Reset mid-frame: outputs return to the reset state on the next edge, and the first post-reset frame begins with a fresh shadow load.

Optional Feature:
- Macro: SM_HEX_DISPLAY_DIM_EN.
- Defined:
  - Adds input brightness[3:0] and a free-running 4-bit PWM counter, reset to 0.
  - The active anode is asserted only while pwm_cnt <= brightness. 15 = always on; 0 = 1/16 duty.
  - Segment outputs are unaffected.
- Undefined:
  - No brightness port; the anode is always asserted during its slot.

Decomposition:
- Package sm_hex_display_pkg holds:
  - SEG_W = 7.
  - The 16-entry hex-to-segment constant table (active-high).
  - Segment bit-order constants.
- One combinational sub-module, sm_hex_to_seg (nibble -> 7 bits, active-high), instantiated once on the selected nibble.

Test Plan:
- Reset then release, DIGITS=8, tick_div=3, number=32'h12345678:
  - frame_start pulses at cycle 1 and then every 32 cycles.
  - anodes walk 11111110 -> 01111111, each held 4 cycles.
  - Digit 0 segments = ~1111111 (8).
- number=32'h0000_00A0, blank_lz=1:
  - Only digits 0 and 1 are lit, showing 0 and A.
  - Digits 2..7 keep anodes inactive for their whole slot.
  - With blank_lz=0, all 8 digits are lit.
- Change number from 32'h11111111 to 32'h22222222 mid-frame:
  - Digits keep showing 1 until the next frame_start.
  - All digits show 2 in the following frame.
- tick_div=100 and count at 50, then tick_div set to 10: the count wraps at the next edge and the index advances. tick_div=0: the index advances every clock.
- digit_en=8'b1111_0111, dots=8'h01:
  - Digit 3 slot is dark.
  - The dot is lit only during the digit 0 slot.
- rst asserted mid-frame for 1 cycle:
  - All outputs go to reset values next edge.
  - Index restarts at 0 and a new frame_start follows release.
  - With SM_HEX_DISPLAY_DIM_EN and brightness=3: the anode is active 4 of every 16 clocks.
